// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter and its sequence checker.
package counter_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int unsigned COUNT_WIDTH = 8;
   // Match/miss thresholds are limited to 1..15.
   localparam int unsigned PHASE_CNT_W = 4;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating counter: clear takes effect first, then increment, holding at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_base;

   always_comb begin
      w_base = clr ? '0 : r_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (inc && (w_base != '1)) begin
         r_cnt <= w_base + W'(1);
      end else begin
         r_cnt <= w_base;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/counter_checker.sv
// Locks onto a +1-per-sample count stream and counts/flags every deviation while locked.
module counter_checker
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = COUNT_WIDTH,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [WIDTH-1:0] q_in,
   input  logic             clear_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WIDTH-1:0]       r_expected;
   logic [WIDTH-1:0]       w_expected_nxt;
   logic                   r_err_pulse;
   logic [PHASE_CNT_W-1:0] w_match_cnt;
   logic [PHASE_CNT_W-1:0] w_miss_cnt;
   logic                   w_hit;
   logic                   w_err;
   logic                   w_match_inc;
   logic                   w_match_clr;
   logic                   w_miss_inc;
   logic                   w_miss_clr;

   assign w_hit = (q_in == r_expected);

   // Match count counts samples in the current run (the run's first sample is 1),
   // so lock is declared when a matching sample arrives with the count already at
   // LOCK_CNT, i.e. on the LOCK_CNT-th consecutive correct increment.
   always_comb begin
      w_state_nxt    = r_state;
      w_expected_nxt = r_expected;
      w_err          = 1'b0;
      w_match_inc    = 1'b0;
      w_match_clr    = 1'b0;
      w_miss_inc     = 1'b0;
      w_miss_clr     = 1'b0;
      if (valid) begin
         case (r_state)
            HUNT: begin
               w_expected_nxt = q_in + WIDTH'(1);
               w_match_clr    = 1'b1;
               w_match_inc    = 1'b1;
               w_miss_clr     = 1'b1;
               w_state_nxt    = (LOCK_CNT == 1) ? LOCKED : LOCKING;
            end
            LOCKING: begin
               if (w_hit) begin
                  w_expected_nxt = r_expected + WIDTH'(1);
                  if (w_match_cnt == PHASE_CNT_W'(LOCK_CNT)) begin
                     w_state_nxt = LOCKED;
                     w_miss_clr  = 1'b1;
                  end else begin
                     w_match_inc = 1'b1;
                  end
               end else begin
                  w_expected_nxt = q_in + WIDTH'(1);
                  w_match_clr    = 1'b1;
                  w_match_inc    = 1'b1;
               end
            end
            LOCKED: begin
               if (w_hit) begin
                  w_expected_nxt = r_expected + WIDTH'(1);
                  w_miss_clr     = 1'b1;
               end else begin
                  w_err          = 1'b1;
                  w_expected_nxt = q_in + WIDTH'(1);
                  if ((w_miss_cnt + PHASE_CNT_W'(1)) == PHASE_CNT_W'(LOSS_CNT)) begin
                     w_state_nxt = LOCKING;
                     w_miss_clr  = 1'b1;
                     w_match_clr = 1'b1;
                     w_match_inc = 1'b1;
                  end else begin
                     w_miss_inc = 1'b1;
                  end
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= HUNT;
         r_expected  <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_expected  <= w_expected_nxt;
         r_err_pulse <= w_err;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_err),
      .clr (clear_err),
      .cnt (err_count)
   );

   sat_counter #(.W(PHASE_CNT_W)) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_match_inc),
      .clr (w_match_clr),
      .cnt (w_match_cnt)
   );

   sat_counter #(.W(PHASE_CNT_W)) u_miss_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_miss_inc),
      .clr (w_miss_clr),
      .cnt (w_miss_cnt)
   );

   assign locked    = (r_state == LOCKED);
   assign err_pulse = r_err_pulse;
   assign expected  = r_expected;

endmodule
